// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_if
//  Brief    : Start/operand/result bundle for the bit-serial subtractor.
//  Revision : 1.0
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : LSB-first bit-serial a - b - borrow_in, one full-subtractor cell.
//  Revision : 1.0
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave sif
);
    localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             bit_d;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        bit_d     = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // New bit enters at the MSB so the LSB-first stream lands in place.
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = bit_d;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;

        case (state_q)
            ST_IDLE: begin
                if (sif.start) begin
                    a_d     = sif.a;
                    b_d     = sif.b;
                    br_d    = sif.borrow_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign sif.busy       = (state_q == ST_SHIFT);
    assign sif.done       = (state_q == ST_DONE);
    assign sif.diff       = diff_q;
    assign sif.borrow_out = bout_q;
endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b - borrow_in, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtract counterpart to the team's adder datapath cells, and is used where area matters more than latency. Operands are captured on a start handshake. The result is presented with a one-cycle done pulse and held until the next operation completes.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 1 or greater.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request to begin; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
borrow_in  input  1  initial borrow; captured on accepted start
busy  output  1  high while an operation is in progress (SHIFT state)
done  output  1  one-cycle pulse marking diff and borrow_out as newly valid
diff  output  WIDTH  result (a - b - borrow_in) mod 2^WIDTH
borrow_out  output  1  final borrow; 1 when a < b + borrow_in (unsigned)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, bit counter and borrow flop are cleared.
  - Reset has priority over all other inputs.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: latch a, b and borrow_in into internal registers; clear the counter; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1): on each edge, with ai/bi the current LSBs of the operand shift registers and br the borrow flop:
  - d = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - d is shifted into the MSB of the result shift register, which shifts right.
  - Both operand registers shift right.
  - The counter increments.
  - On the edge that processes bit WIDTH-1: load diff from the completed result register, load borrow_out from br_next, and go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Go to IDLE on the next edge unconditionally.
- Start handling:
  - start is ignored in SHIFT and DONE; there is no queueing.
  - A start held high through DONE is accepted on the first IDLE edge.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH. Minimum spacing between accepted starts is WIDTH+2 edges.
- Output holding:
  - diff and borrow_out change only on entry to DONE, or on reset.
  - They hold their values through IDLE and through a subsequent SHIFT.
- Input stability: a, b and borrow_in may change freely after the accepting edge.
- WIDTH=1: SHIFT lasts one cycle, so done is high in the cycle after edge k+1.
- Arithmetic: unsigned modulo 2^WIDTH. borrow_out equals the inverse of the carry of a + ~b + ~borrow_in.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, borrow_in=0, start pulsed -> done after 9 edges; diff=0x1E, borrow_out=0; busy high for exactly 8 cycles.
- a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1; then a=0x80, b=0x80, borrow_in=1 -> diff=0xFF, borrow_out=1; a=0xFF, b=0x00, borrow_in=1 -> diff=0xFE, borrow_out=0.
- start re-asserted with new operands during SHIFT and in the DONE cycle -> ignored; result matches the first operands; held start is accepted on the following IDLE edge.
- rst_n=0 for one edge at the 4th SHIFT cycle -> busy=0, done never pulses, diff=0, borrow_out=0; a new start afterwards yields a correct result.
- After a completed operation, hold start=0 for 20 cycles with changing a/b -> diff and borrow_out stay stable; done stays low.
- Randomised 1000 operations, WIDTH=8 and WIDTH=1 -> diff and borrow_out match the reference model {borrow_out,diff} = a - b - borrow_in (WIDTH+1 bits, two's complement); done-to-start latency is exact.
